branch_resolve_ctrl: RTL and testbench

Branch-resolution controller for the pipelined RV32I core. It drives the shared branch comparator (cmp) from the EX-stage branch operands and resolves the branch against the fetch-time prediction. On a mispredict it issues a registered redirect and flush. It owns a 2-bit saturating-counter branch history table (BHT) that supplies the prediction to IF and is trained at resolution.

---
 rtl/branch_resolve_ctrl.sv | 130 +++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch-resolution controller: drives the shared comparator, resolves EX branches
// against the fetch-time prediction, issues registered redirect/flush and trains a 2-bit BHT.
module branch_resolve_ctrl #(
  parameter int         BHT_IDX_BITS = 6,
  parameter logic [1:0] CNT_RESET    = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_b_imm,
  input  logic        ex_pred_taken,
  input  logic        stall,
  output logic [31:0] cmp_rs1,
  output logic [31:0] cmp_rs2,
  output logic [2:0]  cmp_op,
  output logic        cmp_sel,
  input  logic        cmp_br_en,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] mispredict_count
);

  localparam int   BHT_ENTRIES = 1 << BHT_IDX_BITS;
  localparam logic CMP_SEL_RS2 = 1'b0;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } state_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;
  logic [1:0]  bht_q [BHT_ENTRIES];
  logic [1:0]  bht_d [BHT_ENTRIES];

  logic [BHT_IDX_BITS-1:0] if_idx;
  logic [BHT_IDX_BITS-1:0] ex_idx;
  logic                    branch_ok;
  logic                    taken;
  logic                    resolve;

  assign if_idx = if_pc[BHT_IDX_BITS+1:2];
  assign ex_idx = ex_pc[BHT_IDX_BITS+1:2];

  assign cmp_rs1 = ex_rs1;
  assign cmp_rs2 = ex_rs2;
  assign cmp_op  = ex_funct3;
  assign cmp_sel = CMP_SEL_RS2;

  // Registered read path: a same-cycle write lands at the edge, so the lookup sees the old count.
  assign if_pred_taken = bht_q[if_idx][1];

  assign redirect         = (state_q == ST_REDIRECT);
  assign flush            = (state_q == ST_REDIRECT);
  assign redirect_pc      = redirect_pc_q;
  assign mispredict_count = mispredict_count_q;

  always_comb begin
    branch_ok = 1'b0;
    case (ex_funct3)
      F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: branch_ok = 1'b1;
      default:                                          branch_ok = 1'b0;
    endcase
  end

  assign taken   = branch_ok & cmp_br_en;
  assign resolve = ex_valid & ~stall & (state_q == ST_IDLE) & branch_ok;

  always_comb begin
    state_d            = state_q;
    redirect_pc_d      = redirect_pc_q;
    mispredict_count_d = mispredict_count_q;
    bht_d              = bht_q;
    case (state_q)
      ST_IDLE: begin
        if (resolve) begin
          bht_d[ex_idx] = taken ? sat_inc(bht_q[ex_idx]) : sat_dec(bht_q[ex_idx]);
          if (taken != ex_pred_taken) begin
            state_d            = ST_REDIRECT;
            mispredict_count_d = mispredict_count_q + 32'd1;
            redirect_pc_d      = taken ? (ex_pc + ex_b_imm) : (ex_pc + 32'd4);
          end
        end
      end
      ST_REDIRECT: begin
        // Fetch consumes the redirect on the first unstalled edge; EX holds wrong-path work meanwhile.
        if (!stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      redirect_pc_q      <= 32'd0;
      mispredict_count_q <= 32'd0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_RESET;
    end else begin
      state_q            <= state_d;
      redirect_pc_q      <= redirect_pc_d;
      mispredict_count_q <= mispredict_count_d;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= bht_d[i];
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with hand-computed expectations.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_b_imm;
  logic        ex_pred_taken;
  logic        stall;
  logic [31:0] cmp_rs1;
  logic [31:0] cmp_rs2;
  logic [2:0]  cmp_op;
  logic        cmp_sel;
  logic        cmp_br_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] mispredict_count;

  int vectors = 0;
  int miscompares = 0;

  branch_resolve_ctrl #(.BHT_IDX_BITS(6), .CNT_RESET(2'b01)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_b_imm(ex_b_imm),
    .ex_pred_taken(ex_pred_taken), .stall(stall),
    .cmp_rs1(cmp_rs1), .cmp_rs2(cmp_rs2), .cmp_op(cmp_op), .cmp_sel(cmp_sel),
    .cmp_br_en(cmp_br_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic branch(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic pred,
                        input logic br_en);
    ex_valid      = 1'b1;
    ex_pc         = pc;
    ex_funct3     = f3;
    ex_rs1        = a;
    ex_rs2        = b;
    ex_b_imm      = imm;
    ex_pred_taken = pred;
    cmp_br_en     = br_en;
  endtask

  initial begin
    rst = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_funct3 = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_b_imm = '0; ex_pred_taken = 1'b0;
    stall = 1'b0; cmp_br_en = 1'b0;
    step();
    rst = 1'b0;

    // 1: post-reset state and comparator pass-through
    if_pc = 32'h0000_0040; #1;
    check("reset_pred", {31'd0, if_pred_taken}, 32'd0);
    check("reset_redirect", {31'd0, redirect}, 32'd0);
    check("reset_flush", {31'd0, flush}, 32'd0);
    check("reset_count", mispredict_count, 32'd0);
    check("reset_rpc", redirect_pc, 32'd0);
    ex_rs1 = 32'hDEAD_BEEF; ex_rs2 = 32'h1234_5678; ex_funct3 = 3'b101; #1;
    check("cmp_rs1", cmp_rs1, 32'hDEAD_BEEF);
    check("cmp_rs2", cmp_rs2, 32'h1234_5678);
    check("cmp_op", {29'd0, cmp_op}, 32'd5);
    check("cmp_sel", {31'd0, cmp_sel}, 32'd0);

    // 2: taken mispredict, beq 5==5 at 0x100, idx 0 goes 01->10
    branch(32'h100, 3'b000, 32'd5, 32'd5, 32'h20, 1'b0, 1'b1);
    step();
    ex_valid = 1'b0; if_pc = 32'h100; #1;
    check("t2_redirect", {31'd0, redirect}, 32'd1);
    check("t2_flush", {31'd0, flush}, 32'd1);
    check("t2_rpc", redirect_pc, 32'h120);
    check("t2_count", mispredict_count, 32'd1);
    check("t2_pred", {31'd0, if_pred_taken}, 32'd1);
    step();
    check("t2_consumed", {31'd0, redirect}, 32'd0);

    // 3: not-taken mispredict, bltu 0xFFFFFFFF<1 false, idx 0 10->01
    branch(32'h200, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0; #1;
    check("t3_redirect", {31'd0, redirect}, 32'd1);
    check("t3_rpc", redirect_pc, 32'h204);
    check("t3_count", mispredict_count, 32'd2);
    step();
    branch(32'h200, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 1'b0, 1'b0);
    step();
    if_pc = 32'h200; #1;
    check("t3_correct_noredir", {31'd0, redirect}, 32'd0);
    check("t3_correct_count", mispredict_count, 32'd2);
    check("t3_pred_00", {31'd0, if_pred_taken}, 32'd0);
    step();
    ex_valid = 1'b0; #1;
    check("t3_sat_low", {31'd0, if_pred_taken}, 32'd0);
    check("t3_sat_noredir", {31'd0, redirect}, 32'd0);

    // 4: stall hold; mispredict at 0x104 (idx 1: 01->10), wrong-path not-taken during REDIRECT
    branch(32'h104, 3'b000, 32'd7, 32'd7, 32'h20, 1'b0, 1'b1);
    step();
    branch(32'h104, 3'b001, 32'd7, 32'd7, 32'h20, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_hold_redirect", {31'd0, redirect}, 32'd1);
      check("t4_hold_flush", {31'd0, flush}, 32'd1);
      check("t4_hold_rpc", redirect_pc, 32'h124);
      check("t4_hold_count", mispredict_count, 32'd3);
      step();
    end
    stall = 1'b0;
    step();
    ex_valid = 1'b0; if_pc = 32'h104; #1;
    check("t4_drop", {31'd0, redirect}, 32'd0);
    check("t4_count", mispredict_count, 32'd3);
    check("t4_bht_kept", {31'd0, if_pred_taken}, 32'd1);
    check("t4_rpc_kept", redirect_pc, 32'h124);

    // 5: saturation high and aliasing, idx 0 starts at 00
    if_pc = 32'h300;
    for (int i = 0; i < 4; i++) begin
      branch(32'h300, 3'b100, 32'd1, 32'd2, 32'h40, 1'b1, 1'b1);
      step();
      check("t5_no_redirect", {31'd0, redirect}, 32'd0);
    end
    ex_valid = 1'b0; #1;
    check("t5_sat_high", {31'd0, if_pred_taken}, 32'd1);
    branch(32'h400, 3'b101, 32'd1, 32'd2, 32'h40, 1'b0, 1'b0);
    step();
    check("t5_alias_10", {31'd0, if_pred_taken}, 32'd1);
    #1;
    check("t5_same_cycle_old", {31'd0, if_pred_taken}, 32'd1);
    step();
    ex_valid = 1'b0; #1;
    check("t5_alias_01", {31'd0, if_pred_taken}, 32'd0);
    check("t5_count", mispredict_count, 32'd3);

    // 6: reset mid-REDIRECT, then non-branch funct3 values
    branch(32'h104, 3'b001, 32'd1, 32'd1, 32'h10, 1'b1, 1'b0);
    step();
    #1;
    check("t6_redirect", {31'd0, redirect}, 32'd1);
    check("t6_rpc", redirect_pc, 32'h108);
    check("t6_count", mispredict_count, 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    branch(32'h108, 3'b000, 32'd1, 32'd1, 32'h10, 1'b0, 1'b1);
    stall = 1'b1;
    if_pc = 32'h104; #1;
    check("t6_rst_redirect", {31'd0, redirect}, 32'd0);
    check("t6_rst_flush", {31'd0, flush}, 32'd0);
    check("t6_rst_count", mispredict_count, 32'd0);
    check("t6_rst_rpc", redirect_pc, 32'd0);
    check("t6_rst_bht", {31'd0, if_pred_taken}, 32'd0);
    step();
    check("t6_stall_noresolve", {31'd0, redirect}, 32'd0);
    stall = 1'b0;
    branch(32'h108, 3'b010, 32'd1, 32'd1, 32'h10, 1'b1, 1'b1);
    step();
    ex_funct3 = 3'b011;
    step();
    ex_valid = 1'b0; if_pc = 32'h108; #1;
    check("t6_f3_noredir", {31'd0, redirect}, 32'd0);
    check("t6_f3_count", mispredict_count, 32'd0);
    check("t6_f3_bht", {31'd0, if_pred_taken}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
